// File: rtl/fpdiv_if.sv
// Handshake bundle for the single-precision divider: operand request channel
// and result/status response channel.
interface fpdiv_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic        overflow;
  logic        underflow;
  logic        div_by_zero;
  logic        invalid;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, overflow, underflow, div_by_zero, invalid
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c, overflow, underflow, div_by_zero, invalid
  );
endinterface

// File: rtl/fpdiv.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division,
// one quotient bit per cycle, denormals flushed to zero, truncation rounding.
module fpdiv (
  input logic   clk,
  input logic   rst,
  fpdiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t             state_q, state_d;
  logic [25:0]        rem_q, rem_d;
  logic [23:0]        divisor_q, divisor_d;
  logic [24:0]        quot_q, quot_d;
  logic [4:0]         cnt_q, cnt_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               sign_q, sign_d;
  logic [31:0]        c_q, c_d;
  logic               ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d, inv_q, inv_d;

  logic               aZero, aInf, bZero, bInf, signAB;
  logic               geq;
  logic [25:0]        remSub;
  logic signed [9:0]  expAdj;
  logic [22:0]        fracN;

  assign aZero  = (bus.a[30:23] == 8'h00);
  assign aInf   = (bus.a[30:23] == 8'hFF);
  assign bZero  = (bus.b[30:23] == 8'h00);
  assign bInf   = (bus.b[30:23] == 8'hFF);
  assign signAB = bus.a[31] ^ bus.b[31];

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.c           = c_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.invalid     = inv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      sign_q    <= 1'b0;
      c_q       <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      dbz_q     <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      c_q       <= c_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      dbz_q     <= dbz_d;
      inv_q     <= inv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    c_d       = c_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    dbz_d     = dbz_q;
    inv_d     = inv_q;

    geq    = (rem_q >= {2'b00, divisor_q});
    remSub = geq ? (rem_q - {2'b00, divisor_q}) : rem_q;

    // A quotient below 1.0 lands one bit lower and costs one exponent step.
    if (quot_q[24]) begin
      fracN  = quot_q[23:1];
      expAdj = exp_q;
    end else begin
      fracN  = quot_q[22:0];
      expAdj = exp_q - 10'sd1;
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d = signAB;
          if (!aZero && !aInf && !bZero && !bInf) begin
            exp_d     = $signed({2'b00, bus.a[30:23]}) - $signed({2'b00, bus.b[30:23]}) + 10'sd127;
            rem_d     = {2'b00, 1'b1, bus.a[22:0]};
            divisor_d = {1'b1, bus.b[22:0]};
            quot_d    = '0;
            cnt_d     = 5'd24;
            state_d   = DIV;
          end else begin
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            dbz_d   = 1'b0;
            inv_d   = 1'b0;
            state_d = DONE;
            if ((aZero && bZero) || (aInf && bInf)) begin
              c_d   = 32'h7FC0_0000;
              inv_d = 1'b1;
            end else if (aInf || bZero) begin
              c_d   = {signAB, 8'hFF, 23'h0};
              dbz_d = bZero && !aInf;
            end else begin
              c_d = {signAB, 31'h0};
            end
          end
        end
      end
      DIV: begin
        quot_d = {quot_q[23:0], geq};
        rem_d  = remSub << 1;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = NORM;
      end
      NORM: begin
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        dbz_d   = 1'b0;
        inv_d   = 1'b0;
        state_d = DONE;
        if (expAdj <= 10'sd0) begin
          c_d   = {sign_q, 31'h0};
          unf_d = 1'b1;
        end else if (expAdj >= 10'sd255) begin
          c_d   = {sign_q, 8'hFF, 23'h0};
          ovf_d = 1'b1;
        end else begin
          c_d = {sign_q, expAdj[7:0], fracN};
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fpdiv.sv
// Self-checking bench for fpdiv: directed and random operands against an
// arithmetic reference model, plus handshake, backpressure and reset scenarios.
module tb_fpdiv;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpdiv_if bus ();
  fpdiv dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Reference result packed as {invalid, div_by_zero, underflow, overflow, c}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, e;
    bit     za, ia, zb, ib, s;
    longint ma, mb, q;
    logic [22:0] fr;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    za = (ea == 0);
    ia = (ea == 255);
    zb = (eb == 0);
    ib = (eb == 255);
    s  = a[31] ^ b[31];
    if ((za && zb) || (ia && ib)) return {4'b1000, 32'h7FC0_0000};
    if (zb) return {1'b0, !ia, 2'b00, s, 8'hFF, 23'h0};
    if (ia) return {4'b0000, s, 8'hFF, 23'h0};
    if (za || ib) return {4'b0000, s, 31'h0};
    ma = 64'h80_0000 | longint'(a[22:0]);
    mb = 64'h80_0000 | longint'(b[22:0]);
    q  = (ma << 24) / mb;
    e  = ea - eb + 127;
    if (q >= (64'd1 << 24)) fr = q[23:1];
    else begin
      fr = q[22:0];
      e  = e - 1;
    end
    if (e <= 0)   return {4'b0010, s, 31'h0};
    if (e >= 255) return {4'b0001, s, 8'hFF, 23'h0};
    return {4'b0000, s, e[7:0], fr};
  endfunction

  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
           (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    int kind;
    v    = $urandom;
    kind = $urandom_range(0, 9);
    if (kind == 0)      v[30:23] = 8'h00;
    else if (kind == 1) v[30:23] = 8'hFF;
    else                v[30:23] = 8'($urandom_range(1, 254));
    return v;
  endfunction

  task automatic wait_in_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL in_ready_timeout: in_ready=%b want 1", bus.in_ready);
    end
  endtask

  // Latency counts clock edges from the one that accepts the operands up to
  // the first edge after which out_valid is high.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit holdReady,
                        output logic [31:0] rc, output logic [3:0] rf, output int lat);
    wait_in_ready();
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = holdReady;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    rc = bus.c;
    rf = {bus.invalid, bus.div_by_zero, bus.underflow, bus.overflow};
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = holdReady;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 32'h40C0_0000;
    bus.b         = 32'h4000_0000;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++;
    if (bus.c !== 32'h0) begin bad++; $display("[TB] FAIL reset_c: got %h want 00000000", bus.c); end
    total++;
    if ({bus.invalid, bus.div_by_zero, bus.underflow, bus.overflow} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b want 0000",
               {bus.invalid, bus.div_by_zero, bus.underflow, bus.overflow});
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_wins_capture: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [12] = '{32'h40C0_0000, 32'h3F80_0000, 32'hC080_0000, 32'h7F00_0000,
                             32'h0080_0000, 32'hBF80_0000, 32'h0000_0000, 32'h7F80_0000,
                             32'h0000_0001, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000};
    logic [31:0] vb [12] = '{32'h4000_0000, 32'h4040_0000, 32'h4000_0000, 32'h0080_0000,
                             32'h7F00_0000, 32'h0000_0000, 32'h0000_0000, 32'hFF80_0000,
                             32'h3F80_0000, 32'h7F80_0000, 32'h3F80_0000, 32'h0000_0000};
    logic [31:0] vc [12] = '{32'h4040_0000, 32'h3EAA_AAAA, 32'hC000_0000, 32'h7F80_0000,
                             32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000,
                             32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 32'hFF80_0000};
    logic [3:0]  vf [12] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100,
                             4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    int          vl [12] = '{27, 27, 27, 27, 27, 1, 1, 1, 1, 1, 1, 1};
    logic [31:0] rc;
    logic [3:0]  rf;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      run_op(va[i], vb[i], 1'b0, rc, rf, lat);
      total++;
      if (rc !== vc[i]) begin bad++; $display("[TB] FAIL directed_c[%0d]: got %h want %h", i, rc, vc[i]); end
      total++;
      if (rf !== vf[i]) begin bad++; $display("[TB] FAIL directed_flags[%0d]: got %b want %b", i, rf, vf[i]); end
      total++;
      if (lat != vl[i]) begin bad++; $display("[TB] FAIL directed_latency[%0d]: got %0d want %0d", i, lat, vl[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, rc;
    logic [3:0]  rf;
    logic [35:0] exp;
    int          lat, wantLat;
    for (int i = 0; i < 40; i++) begin
      a = rand_operand();
      b = rand_operand();
      exp = model(a, b);
      wantLat = is_special(a, b) ? 1 : 27;
      run_op(a, b, 1'b0, rc, rf, lat);
      total++;
      if (rc !== exp[31:0] || rf !== exp[35:32]) begin
        bad++;
        $display("[TB] FAIL random[%0d] %h/%h: got c=%h f=%b want c=%h f=%b", i, a, b, rc, rf, exp[31:0], exp[35:32]);
      end
      total++;
      if (lat != wantLat) begin bad++; $display("[TB] FAIL random_latency[%0d]: got %0d want %0d", i, lat, wantLat); end
    end
  endtask

  task automatic test_backpressure();
    logic [35:0] exp;
    int n;
    exp = model(32'h3F80_0000, 32'h4040_0000);
    wait_in_ready();
    bus.a = 32'h3F80_0000;
    bus.b = 32'h4040_0000;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.a = 32'h40C0_0000;
    bus.b = 32'h4000_0000;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.c !== exp[31:0] ||
          {bus.invalid, bus.div_by_zero, bus.underflow, bus.overflow} !== exp[35:32]) begin
        bad++;
        $display("[TB] FAIL hold_stable[%0d]: got v=%b c=%h want v=1 c=%h", i, bus.out_valid, bus.c, exp[31:0]);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL accept_release: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ignored_in_valid: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rc;
    logic [3:0]  rf;
    int          lat;
    wait_in_ready();
    bus.a = 32'h3F80_0000;
    bus.b = 32'h4040_0000;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_reset: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    run_op(32'h40C0_0000, 32'h4000_0000, 1'b0, rc, rf, lat);
    total++;
    if (rc !== 32'h4040_0000 || rf !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL after_reset_result: got c=%h f=%b want c=40400000 f=0000", rc, rf);
    end
    total++;
    if (lat != 27) begin bad++; $display("[TB] FAIL after_reset_latency: got %0d want 27", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, rc;
    logic [3:0]  rf;
    logic [35:0] exp;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      a = {1'($urandom), 8'($urandom_range(60, 190)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(60, 190)), 23'($urandom)};
      exp = model(a, b);
      run_op(a, b, 1'b1, rc, rf, lat);
      total++;
      if (rc !== exp[31:0] || rf !== exp[35:32]) begin
        bad++;
        $display("[TB] FAIL b2b_result[%0d]: got c=%h f=%b want c=%h f=%b", i, rc, rf, exp[31:0], exp[35:32]);
      end
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_done_one_cycle[%0d]: out_valid=%b in_ready=%b want 0 1", i, bus.out_valid, bus.in_ready);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
